// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path.
//   - Opcode encodings (upper nibble of the instruction register).
//   - Microstep encodings T0..T4 for the fixed five-cycle frame.
//   - Bit positions of the control word produced by control_decoder.
package cpu_pkg;

    localparam int STEPS = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control word bit indices
    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_LOAD   = 5;
    localparam int CW_LOAD_IR    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OUT    = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    localparam int CW_HALT       = 15;
    localparam int CW_W          = 16;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational microcode decoder.
//   step       : current microstep (T0..T4)
//   opcode     : instruction[7:4], only meaningful from T2 onward
//   carry_flag : registered ALU carry, gates JC
//   zero_flag  : registered ALU zero, gates JZ
//   cw         : raw control word (no halt/reset masking applied here)
module control_decoder
    import cpu_pkg::*;
(
    input  logic [2:0]  step,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output ctrl_word_t  cw
);

    always_comb begin
        cw = '0;
        case (step)
            T0: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_LOAD_IR] = 1'b1;
                cw[CW_PC_INC]  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                    end
                    // Flags are sampled live here, so a flags_load in the
                    // previous instruction's T4 is already visible.
                    OP_JC: begin
                        cw[CW_IR_OUT]  = carry_flag;
                        cw[CW_PC_LOAD] = carry_flag;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT]  = zero_flag;
                        cw[CW_PC_LOAD] = zero_flag;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                    OP_HLT: cw[CW_HALT] = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_RAM_LOAD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]    = 1'b1;
                    cw[CW_A_LOAD]     = 1'b1;
                    cw[CW_FLAGS_LOAD] = 1'b1;
                    cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microstep sequencer for the 8-bit CPU.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   instruction       : IR contents; [7:4] opcode decoded from T2
//   carry/zero_flag   : registered ALU flags for conditional jumps
//   *_out/*_load/...  : bus strobes, combinational for the whole cycle
//   halt              : machine halted, held until reset
//   step              : current microstep, for debug
// Holds the step counter and halted flag; the decoder supplies the raw
// control word, which is masked here while in reset or halted.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instruction,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_load,
    output logic       load_ir,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halt,
    output logic [2:0] step
);

    logic [2:0] step_q, step_d;
    logic       halted, halted_d;
    ctrl_word_t cw, cw_m;

    control_decoder u_dec (
        .step       (step_q),
        .opcode     (instruction[7:4]),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .cw         (cw)
    );

    // HLT freezes step at T2 rather than advancing, so the frame stays put.
    always_comb begin
        step_d   = step_q;
        halted_d = halted;
        if (!halted) begin
            if (cw[CW_HALT])
                halted_d = 1'b1;
            else if (step_q == 3'(STEPS - 1))
                step_d = T0;
            else
                step_d = step_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= T0;
            halted <= 1'b0;
        end else begin
            step_q <= step_d;
            halted <= halted_d;
        end
    end

    assign cw_m = (reset || halted) ? '0 : cw;

    assign pc_out     = cw_m[CW_PC_OUT];
    assign pc_inc     = cw_m[CW_PC_INC];
    assign pc_load    = cw_m[CW_PC_LOAD];
    assign mar_load   = cw_m[CW_MAR_LOAD];
    assign ram_out    = cw_m[CW_RAM_OUT];
    assign ram_load   = cw_m[CW_RAM_LOAD];
    assign load_ir    = cw_m[CW_LOAD_IR];
    assign ir_out     = cw_m[CW_IR_OUT];
    assign a_load     = cw_m[CW_A_LOAD];
    assign a_out      = cw_m[CW_A_OUT];
    assign b_load     = cw_m[CW_B_LOAD];
    assign alu_out    = cw_m[CW_ALU_OUT];
    assign alu_sub    = cw_m[CW_ALU_SUB];
    assign flags_load = cw_m[CW_FLAGS_LOAD];
    assign out_load   = cw_m[CW_OUT_LOAD];
    assign halt       = !reset && (halted || cw[CW_HALT]);
    assign step       = step_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a vector table of per-cycle inputs and
// expected strobes/step, plus hand-written HLT and reset-mid-STA sequences.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, load_ir, ir_out;
    logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt;
    logic [2:0] step;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ram_out(ram_out), .ram_load(ram_load), .load_ir(load_ir), .ir_out(ir_out),
        .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
        .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
        .halt(halt), .step(step)
    );

    // Bench-local strobe encoding (MSB first in the order below)
    localparam logic [15:0] PCO = 16'h8000, PCI = 16'h4000, PCL = 16'h2000, MARL = 16'h1000;
    localparam logic [15:0] RAMO = 16'h0800, RAML = 16'h0400, IRL = 16'h0200, IRO = 16'h0100;
    localparam logic [15:0] AL = 16'h0080, AO = 16'h0040, BL = 16'h0020, ALUO = 16'h0010;
    localparam logic [15:0] SUBS = 16'h0008, FL = 16'h0004, OUTL = 16'h0002, HLT = 16'h0001;
    localparam logic [15:0] F0 = PCO | MARL;
    localparam logic [15:0] F1 = RAMO | IRL | PCI;

    typedef struct {
        logic       rst;
        logic [7:0] instr;
        logic       c;
        logic       z;
        logic [2:0] step;
        logic [15:0] ctrl;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic r, input logic [7:0] i, input logic c,
                                input logic z, input logic [2:0] s, input logic [15:0] w);
        vec_t v;
        v.rst = r; v.instr = i; v.c = c; v.z = z; v.step = s; v.ctrl = w;
        return v;
    endfunction

    task automatic add_frame(input logic [7:0] i, input logic c, input logic z,
                             input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4);
        vecs.push_back(mk(1'b0, i, c, z, 3'd0, F0));
        vecs.push_back(mk(1'b0, i, c, z, 3'd1, F1));
        vecs.push_back(mk(1'b0, i, c, z, 3'd2, t2));
        vecs.push_back(mk(1'b0, i, c, z, 3'd3, t3));
        vecs.push_back(mk(1'b0, i, c, z, 3'd4, t4));
    endtask

    // Drive on the falling edge, sample 1ns later, well clear of the rising edge.
    task automatic apply(input vec_t v);
        logic [15:0] act;
        int drivers;
        @(negedge clk);
        reset = v.rst; instruction = v.instr; carry_flag = v.c; zero_flag = v.z;
        #1;
        n_vec++;
        act = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, load_ir, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt};
        if (act !== v.ctrl) begin
            n_bad++;
            $display("FAIL ctrl vec%0d instr=%h: got %h want %h", n_vec, v.instr, act, v.ctrl);
        end
        if (step !== v.step) begin
            n_bad++;
            $display("FAIL step vec%0d instr=%h: got %0d want %0d", n_vec, v.instr, step, v.step);
        end
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        if (drivers > 1) begin
            n_bad++;
            $display("FAIL bus_drivers vec%0d: got %0d want <=1", n_vec, drivers);
        end
    endtask

    initial begin
        // Reset cycle (a rising edge with reset=1 has already occurred at t=5)
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000));
        add_frame(8'h2A, 1'b0, 1'b0, IRO | MARL, RAMO | BL, ALUO | AL | FL);
        add_frame(8'h3A, 1'b0, 1'b0, IRO | MARL, RAMO | BL, ALUO | AL | FL | SUBS);
        add_frame(8'h7C, 1'b1, 1'b0, IRO | PCL, 16'h0, 16'h0);
        add_frame(8'h7C, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
        add_frame(8'h85, 1'b0, 1'b1, IRO | PCL, 16'h0, 16'h0);
        add_frame(8'h85, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        add_frame(8'hB7, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
        add_frame(8'h13, 1'b0, 1'b0, IRO | MARL, RAMO | AL, 16'h0);
        add_frame(8'h4F, 1'b0, 1'b0, IRO | MARL, AO | RAML, 16'h0);
        add_frame(8'h57, 1'b0, 1'b0, IRO | AL, 16'h0, 16'h0);
        add_frame(8'h63, 1'b0, 1'b0, IRO | PCL, 16'h0, 16'h0);
        add_frame(8'hE0, 1'b0, 1'b0, AO | OUTL, 16'h0, 16'h0);
        add_frame(8'h09, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);

        foreach (vecs[k]) apply(vecs[k]);

        // Reset asserted at T3 of STA: no ram_load, restart at T0
        apply(mk(1'b0, 8'h4F, 1'b0, 1'b0, 3'd0, F0));
        apply(mk(1'b0, 8'h4F, 1'b0, 1'b0, 3'd1, F1));
        apply(mk(1'b0, 8'h4F, 1'b0, 1'b0, 3'd2, IRO | MARL));
        apply(mk(1'b1, 8'h4F, 1'b0, 1'b0, 3'd3, 16'h0));
        apply(mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, F0));
        apply(mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd1, F1));
        for (int s = 2; s < 5; s++) apply(mk(1'b0, 8'h00, 1'b0, 1'b0, 3'(s), 16'h0));

        // HLT: halt from T2, frozen for 10 cycles even with a live opcode
        apply(mk(1'b0, 8'hF0, 1'b0, 1'b0, 3'd0, F0));
        apply(mk(1'b0, 8'hF0, 1'b0, 1'b0, 3'd1, F1));
        apply(mk(1'b0, 8'hF0, 1'b0, 1'b0, 3'd2, HLT));
        for (int n = 0; n < 10; n++) apply(mk(1'b0, 8'h2A, 1'b1, 1'b1, 3'd2, HLT));
        apply(mk(1'b1, 8'h2A, 1'b1, 1'b1, 3'd2, 16'h0));
        apply(mk(1'b0, 8'h2A, 1'b0, 1'b0, 3'd0, F0));
        apply(mk(1'b0, 8'h2A, 1'b0, 1'b0, 3'd1, F1));
        apply(mk(1'b0, 8'h2A, 1'b0, 1'b0, 3'd2, IRO | MARL));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
